// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory controller.
// Holds the FSM state encoding and the grant-index width helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE
  } state_t;

  localparam int DEF_CONSUMERS = 4;
  localparam int GRANT_BITS    = $clog2(DEF_CONSUMERS);

  function automatic int grant_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester at or above the pointer, with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [GW-1:0] pointer,
  output logic          grant_valid,
  output logic [GW-1:0] grant_index
);

  int idx;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(pointer) + k;
      if (idx >= N) idx = idx - N;
      if (request[idx]) begin
        grant_valid = 1'b1;
        grant_index = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Shares one data-memory port among several LSUs.
// Round-robin grant, one transaction in flight, one-cycle ready pulse.
module data_mem_controller
  import data_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int GW = grant_bits(NUM_CONSUMERS);

  state_t                           state;
  state_t                           state_nxt;
  logic   [GW-1:0]                  ptr_q;
  logic   [GW-1:0]                  grant_q;
  logic                             is_read_q;
  logic   [NUM_CONSUMERS*DATA_BITS-1:0] rdata_q;
  logic   [NUM_CONSUMERS-1:0]       request;
  logic                             grant_valid;
  logic   [GW-1:0]                  grant_index;
  logic   [GW-1:0]                  ptr_nxt;
  logic                             take;

  assign request = consumer_read_valid | consumer_write_valid;
  assign take    = (state == IDLE) && grant_valid;
  assign ptr_nxt = (grant_index == GW'(NUM_CONSUMERS - 1))
                 ? '0 : grant_index + GW'(1);

  assign consumer_read_data = rdata_q;

  rr_arbiter #(
    .N  (NUM_CONSUMERS),
    .GW (GW)
  ) u_arb (
    .request     (request),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (grant_valid)
          state_nxt = consumer_read_valid[grant_index]
                    ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:
        if (mem_read_ready) state_nxt = RELEASE;
      WRITE_WAIT:
        if (mem_write_ready) state_nxt = RELEASE;
      RELEASE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid       = 1'b0;
    mem_write_valid      = 1'b0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    unique case (state)
      READ_WAIT:  mem_read_valid  = 1'b1;
      WRITE_WAIT: mem_write_valid = 1'b1;
      RELEASE:
        if (is_read_q) consumer_read_ready[grant_q]  = 1'b1;
        else           consumer_write_ready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  // Request fields are captured once at grant and held until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q             <= '0;
      grant_q           <= '0;
      is_read_q         <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      rdata_q           <= '0;
    end else begin
      if (take) begin
        grant_q   <= grant_index;
        ptr_q     <= ptr_nxt;
        is_read_q <= consumer_read_valid[grant_index];
        if (consumer_read_valid[grant_index]) begin
          mem_read_address <=
            consumer_read_address[grant_index*ADDR_BITS +: ADDR_BITS];
        end else begin
          mem_write_address <=
            consumer_write_address[grant_index*ADDR_BITS +: ADDR_BITS];
          mem_write_data <=
            consumer_write_data[grant_index*DATA_BITS +: DATA_BITS];
        end
      end
      if (state == READ_WAIT && mem_read_ready)
        rdata_q[grant_q*DATA_BITS +: DATA_BITS] <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller.
// Drives and samples on the falling edge; expected values are hand-derived.
module tb_data_mem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rv, wv, crr, cwr;
  logic [31:0] ra, wa, wd, crd;
  logic        mrv, mrr, mwv, mwr;
  logic [7:0]  mra, mrd, mwa, mwd;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_mem_controller #(
    .NUM_CONSUMERS (4),
    .ADDR_BITS     (8),
    .DATA_BITS     (8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    mrr = 1'b0; mrd = '0; mwr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mrv", 32'(mrv), 0);
    chk("rst_mwv", 32'(mwv), 0);
    chk("rst_crr", 32'(crr), 0);
    chk("rst_cwr", 32'(cwr), 0);
    chk("rst_crd", crd, 0);
    reset = 1'b0;

    // single read, consumer 2, zero-wait memory
    rv = 4'b0100; ra[16 +: 8] = 8'h3C;
    @(negedge clk);
    chk("rd_mrv", 32'(mrv), 1);
    chk("rd_addr", 32'(mra), 32'h3C);
    chk("rd_mwv", 32'(mwv), 0);
    mrr = 1'b1; mrd = 8'hA5;
    @(negedge clk);
    chk("rd_crr", 32'(crr), 32'b0100);
    chk("rd_data2", 32'(crd[16 +: 8]), 32'hA5);
    chk("rd_cwr", 32'(cwr), 0);
    chk("rd_mrv_off", 32'(mrv), 0);
    mrr = 1'b0;
    @(negedge clk);
    chk("stale_crr", 32'(crr), 0);
    chk("stale_mrv", 32'(mrv), 0);
    rv = '0;
    @(negedge clk);
    chk("stale_nodup", 32'(mrv), 0);

    // wrap-around: pointer is 3, consumers 0 and 3 request
    rv = 4'b1001; ra[0 +: 8] = 8'h40; ra[24 +: 8] = 8'h43;
    @(negedge clk);
    chk("wrap_mrv", 32'(mrv), 1);
    chk("wrap_addr3", 32'(mra), 32'h43);
    mrr = 1'b1; mrd = 8'h77;
    @(negedge clk);
    chk("wrap_crr3", 32'(crr), 32'b1000);
    chk("wrap_data3", 32'(crd[24 +: 8]), 32'h77);
    mrr = 1'b0; rv[3] = 1'b0;
    @(negedge clk);
    chk("wrap_idle", 32'(crr), 0);
    @(negedge clk);
    chk("wrap_addr0", 32'(mra), 32'h40);
    mrr = 1'b1; mrd = 8'h88;
    @(negedge clk);
    chk("wrap_crr0", 32'(crr), 32'b0001);
    chk("wrap_data0", 32'(crd[0 +: 8]), 32'h88);
    chk("wrap_keep3", 32'(crd[24 +: 8]), 32'h77);
    chk("wrap_keep2", 32'(crd[16 +: 8]), 32'hA5);
    mrr = 1'b0; rv[0] = 1'b0;
    @(negedge clk);

    // read wins over write on consumer 1
    rv = 4'b0010; wv = 4'b0010;
    ra[8 +: 8] = 8'h61; wa[8 +: 8] = 8'h62; wd[8 +: 8] = 8'h63;
    @(negedge clk);
    chk("rw_mrv", 32'(mrv), 1);
    chk("rw_mwv", 32'(mwv), 0);
    chk("rw_raddr", 32'(mra), 32'h61);
    mrr = 1'b1; mrd = 8'h5A;
    @(negedge clk);
    chk("rw_crr", 32'(crr), 32'b0010);
    chk("rw_cwr0", 32'(cwr), 0);
    mrr = 1'b0; rv = '0;
    @(negedge clk);
    chk("rw_idle", 32'(mwv), 0);
    @(negedge clk);
    chk("rw_mwv2", 32'(mwv), 1);
    chk("rw_waddr", 32'(mwa), 32'h62);
    chk("rw_wdata", 32'(mwd), 32'h63);
    chk("rw_mrv2", 32'(mrv), 0);
    mwr = 1'b1;
    @(negedge clk);
    chk("rw_cwr", 32'(cwr), 32'b0010);
    chk("rw_crr2", 32'(crr), 0);
    mwr = 1'b0; wv = '0;
    @(negedge clk);

    // stalled read with address changed mid-wait
    rv = 4'b0100; ra[16 +: 8] = 8'h55;
    @(negedge clk);
    chk("stall_addr0", 32'(mra), 32'h55);
    ra[16 +: 8] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_mrv", 32'(mrv), 1);
      chk("stall_addr", 32'(mra), 32'h55);
      chk("stall_crr", 32'(crr), 0);
    end
    mrr = 1'b1; mrd = 8'h3E;
    @(negedge clk);
    chk("stall_pulse", 32'(crr), 32'b0100);
    chk("stall_data", 32'(crd[16 +: 8]), 32'h3E);
    mrr = 1'b0; rv = '0;
    @(negedge clk);
    chk("stall_once", 32'(crr), 0);

    // reset during WRITE_WAIT
    wv = 4'b1000; wa[24 +: 8] = 8'h7E; wd[24 +: 8] = 8'hE7;
    @(negedge clk);
    chk("rstw_mwv", 32'(mwv), 1);
    chk("rstw_addr", 32'(mwa), 32'h7E);
    #2 reset = 1'b1;
    #1;
    chk("rstw_mwv0", 32'(mwv), 0);
    chk("rstw_addr0", 32'(mwa), 0);
    chk("rstw_data0", 32'(mwd), 0);
    chk("rstw_crd0", crd, 0);
    wv = '0; mwr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_cwr", 32'(cwr), 0);
    @(negedge clk);
    chk("rstw_nopulse", 32'(cwr), 0);
    chk("rstw_idle", 32'(mwv), 0);
    mwr = 1'b0;

    // contention: all four write together
    wv = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wa[i*8 +: 8] = 8'h10 + 8'(i);
      wd[i*8 +: 8] = 8'h20 + 8'(i);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ct_mwv", 32'(mwv), 1);
      chk("ct_addr", 32'(mwa), 32'h10 + i);
      chk("ct_data", 32'(mwd), 32'h20 + i);
      mwr = 1'b1;
      @(negedge clk);
      chk("ct_cwr", 32'(cwr), 32'(4'b0001 << i));
      mwr = 1'b0; wv[i] = 1'b0;
      @(negedge clk);
      chk("ct_cwr_off", 32'(cwr), 0);
    end

    // pointer back at 0: consumer 0 beats consumer 3
    rv = 4'b1001; ra[0 +: 8] = 8'hA0; ra[24 +: 8] = 8'hA3;
    @(negedge clk);
    chk("ptr0_addr", 32'(mra), 32'hA0);
    mrr = 1'b1; mrd = 8'h11;
    @(negedge clk);
    chk("ptr0_crr", 32'(crr), 32'b0001);
    mrr = 1'b0; rv = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Shares one data-memory port between NUM_CONSUMERS per-thread load-store units (LSUs).
- Arbitrates between LSU read and write requests round-robin and forwards one transaction at a time to memory.
- Returns the memory response to the granted LSU as a one-cycle ready pulse.
- Sits between the per-core LSU array and the external data memory interface.

Parameters:
- NUM_CONSUMERS, 4, number of LSUs sharing the port (at least 2).
- ADDR_BITS, 8, data memory address width.
- DATA_BITS, 8, data memory word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request, held until ready.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i occupies slice [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  output  NUM_CONSUMERS  per-LSU one-cycle read-complete pulse.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, valid while the matching ready bit is high.
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request, held until ready.
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data.
- consumer_write_ready  output  NUM_CONSUMERS  per-LSU one-cycle write-complete pulse.
- mem_read_valid  output  1  read request to memory.
- mem_read_address  output  ADDR_BITS  memory read address.
- mem_read_ready  input  1  memory read complete; mem_read_data valid this cycle.
- mem_read_data  input  DATA_BITS  memory read data.
- mem_write_valid  output  1  write request to memory.
- mem_write_address  output  ADDR_BITS  memory write address.
- mem_write_data  output  DATA_BITS  memory write data.
- mem_write_ready  input  1  memory write accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0. Reset asserted mid-transaction aborts it with no ready pulse issued.
- FSM states and transitions:
  - IDLE -> READ_WAIT or WRITE_WAIT on a grant.
  - READ_WAIT / WRITE_WAIT -> RELEASE on memory ready.
  - RELEASE -> IDLE.
- Requesting consumer: consumer i requests if read_valid[i] or write_valid[i] is high. If both are high, read wins and the write stays pending.
- Arbitration in IDLE: grant the first requesting consumer scanning from the pointer upward, with wrap-around modulo NUM_CONSUMERS. Register the grant index, then set pointer = grant+1 (wrapping).
- Grant cycle t: at edge t+1, mem_*_valid is 1 and address/data are captured from the granted consumer's slice. Captured values are held stable until memory ready; later consumer input changes are ignored.
- READ_WAIT: hold mem_read_valid until mem_read_ready = 1 at cycle m. At edge m+1:
  - mem_read_valid = 0;
  - consumer_read_data slice[grant] = mem_read_data;
  - consumer_read_ready[grant] = 1 for exactly one cycle;
  - go to RELEASE.
- WRITE_WAIT: same as READ_WAIT using mem_write_ready and consumer_write_ready; no data returned.
- RELEASE: clear all ready bits and go to IDLE. No grant is issued in RELEASE; this covers the LSU's one-cycle valid-drop lag so a stale valid is never re-granted.
- Minimum service time, zero-wait memory: request seen at t, mem valid at t+1, ready pulse at t+2, back in IDLE at t+3.
- Read data slices hold their last value until overwritten. Only the granted slice updates.
- mem_read_valid and mem_write_valid are never high together. At most one consumer ready bit is high in any cycle.
- Memory ready seen while in IDLE or RELEASE is ignored.
- Fairness: with all consumers requesting continuously, each is served once per NUM_CONSUMERS transactions.

Decomposition:
- Package data_mem_pkg holds:
  - the state_t enum {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} (2 bits);
  - a grant-index width constant equal to $clog2(NUM_CONSUMERS).
- One sub-module, rr_arbiter, is natural. It is combinational: inputs are the request vector and pointer; outputs are grant_valid and grant_index. It is reusable for the program-memory controller.

Test Plan:
- Single read: reset, consumer 2 read_valid with address 0x3C, memory returns 0xA5 with zero wait:
  - mem_read_address = 0x3C one cycle later;
  - read_ready[2] pulses one cycle later still, with data slice 2 = 0xA5;
  - no other ready bits assert.
- Contention: consumers 0–3 all assert writes (address 0x10+i, data 0x20+i) at the same time:
  - memory sees writes in order 0, 1, 2, 3, each with matching address and data;
  - each write_ready pulses exactly once;
  - pointer ends at 0.
- Wrap-around: pointer = 3 after serving consumer 2; consumers 0 and 3 request:
  - consumer 3 is served first, then consumer 0.
- Memory stall: read with mem_read_ready held low 5 cycles; change consumer address mid-wait:
  - mem_read_valid stays high with the original address;
  - exactly one ready pulse after ready arrives.
- Read-over-write and stale valid:
  - consumer 1 asserts both read and write: read served first, write served on a later grant;
  - LSU keeps valid high one cycle after its ready pulse: no duplicate memory transaction.
- Reset mid-operation: assert reset during WRITE_WAIT:
  - all outputs 0 immediately (asynchronous);
  - no ready pulse;
  - a new request after reset deasserts is granted starting from consumer 0.
